// File: rtl/memory_store_align_if.sv
// -----------------------------------------------------------------------------
// memory_store_align_if
// Bundles the store-request side (from the LSU) and the write-beat side (to the
// data-bus write channel) of memory_store_align.
//   slave  modport : view taken by memory_store_align itself
//   master modport : view taken by the surrounding LSU / bus environment
// Signals:
//   req_valid/req_ready/req_addr/req_data/is_byte/is_half/is_word/is_double
//   wr_valid/wr_ready/wr_addr/wr_data/wr_strb/wr_last
//   done (final beat accepted pulse), err (rejected request pulse)
// -----------------------------------------------------------------------------
interface memory_store_align_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  is_byte;
    logic                  is_half;
    logic                  is_word;
    logic                  is_double;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic                  wr_last;
    logic                  done;
    logic                  err;

    modport slave (
        input  req_valid, req_addr, req_data, is_byte, is_half, is_word, is_double, wr_ready,
        output req_ready, wr_valid, wr_addr, wr_data, wr_strb, wr_last, done, err
    );

    modport master (
        output req_valid, req_addr, req_data, is_byte, is_half, is_word, is_double, wr_ready,
        input  req_ready, wr_valid, wr_addr, wr_data, wr_strb, wr_last, done, err
    );
endinterface

// File: rtl/memory_store_align.sv
// -----------------------------------------------------------------------------
// memory_store_align
// Store-side lane aligner: accepts one store (addr, right-justified data,
// one-hot size) when idle, shifts the data to its byte lanes, builds byte
// strobes and presents it as one (or, for a lane-crossing store, two) write
// beats on a valid/ready port. One store in flight; all outputs registered.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   bus    : memory_store_align_if.slave (request side + write-beat side)
// Configuration macro:
//   STORE_SPLIT_EN : when defined, stores crossing a bus-word boundary are
//                    issued as two beats; when undefined they are rejected
//                    with an err pulse and the second-beat state is not built.
// -----------------------------------------------------------------------------
module memory_store_align #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int OFF_WIDTH  = $clog2(STRB_WIDTH)
) (
    input logic                clk,
    input logic                rst_n,
    memory_store_align_if.slave bus
);

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
            $error("memory_store_align: DATA_WIDTH must be 32 or 64");
        end
    endgenerate

`ifdef STORE_SPLIT_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND0 = 2'd1, ST_SEND1 = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND0 = 2'd1} state_t;
`endif

    // Expand a byte-strobe vector into a per-bit data mask.
    function automatic logic [DATA_WIDTH-1:0] strb_to_bits(input logic [STRB_WIDTH-1:0] strb);
        logic [DATA_WIDTH-1:0] bits;
        bits = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            bits[8*i +: 8] = {8{strb[i]}};
        end
        return bits;
    endfunction

    state_t                    state_r;
    state_t                    state_next_s;
    logic                      is_double_s;
    logic [STRB_WIDTH-1:0]     size_mask_s;
    logic                      size_legal_s;
    logic [OFF_WIDTH-1:0]      off_s;
    logic [2*STRB_WIDTH-1:0]   mask2_s;
    logic                      cross_s;
    logic                      legal_s;
    logic [DATA_WIDTH-1:0]     lo_data_s;
    logic [ADDR_WIDTH-1:0]     base_addr_s;

    logic                      ready_r;
    logic                      wr_valid_r;
    logic [ADDR_WIDTH-1:0]     wr_addr_r;
    logic [DATA_WIDTH-1:0]     wr_data_r;
    logic [STRB_WIDTH-1:0]     wr_strb_r;
    logic                      wr_last_r;
    logic                      done_r;
    logic                      err_r;

`ifdef STORE_SPLIT_EN
    logic [2*DATA_WIDTH-1:0]   wide_s;
    logic [DATA_WIDTH-1:0]     hi_data_s;
    logic [DATA_WIDTH-1:0]     hi_data_r;
    logic [STRB_WIDTH-1:0]     hi_strb_r;
`endif

    // A double-word size only exists on a 64-bit bus.
    assign is_double_s = (DATA_WIDTH == 64) & bus.is_double;
    assign off_s       = bus.req_addr[OFF_WIDTH-1:0];
    assign base_addr_s = bus.req_addr & {{(ADDR_WIDTH-OFF_WIDTH){1'b1}}, {OFF_WIDTH{1'b0}}};

    // Size decode: exactly one size bit must be set.
    always_comb begin
        size_mask_s  = '0;
        size_legal_s = 1'b0;
        case ({is_double_s, bus.is_word, bus.is_half, bus.is_byte})
            4'b0001: begin size_mask_s = STRB_WIDTH'(8'h01); size_legal_s = 1'b1; end
            4'b0010: begin size_mask_s = STRB_WIDTH'(8'h03); size_legal_s = 1'b1; end
            4'b0100: begin size_mask_s = STRB_WIDTH'(8'h0F); size_legal_s = 1'b1; end
            4'b1000: begin size_mask_s = STRB_WIDTH'(8'hFF); size_legal_s = 1'b1; end
            default: begin size_mask_s = '0;                 size_legal_s = 1'b0; end
        endcase
    end

    // Strobes are computed over two bus words so that bytes spilling past the
    // word boundary land in the upper half and flag a crossing store.
    assign mask2_s   = {{STRB_WIDTH{1'b0}}, size_mask_s} << off_s;
    assign cross_s   = |mask2_s[2*STRB_WIDTH-1:STRB_WIDTH];
    assign lo_data_s = (bus.req_data << {off_s, 3'b000}) & strb_to_bits(mask2_s[STRB_WIDTH-1:0]);

`ifdef STORE_SPLIT_EN
    assign wide_s    = {{DATA_WIDTH{1'b0}}, bus.req_data} << {off_s, 3'b000};
    assign hi_data_s = wide_s[2*DATA_WIDTH-1:DATA_WIDTH] & strb_to_bits(mask2_s[2*STRB_WIDTH-1:STRB_WIDTH]);
    assign legal_s   = size_legal_s;
`else
    assign legal_s   = size_legal_s & ~cross_s;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; wr_last_r low in SEND0 means a second beat follows.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid && legal_s) state_next_s = ST_SEND0;
                else                          state_next_s = ST_IDLE;
            end
            ST_SEND0: begin
                if (bus.wr_ready) begin
`ifdef STORE_SPLIT_EN
                    if (!wr_last_r) state_next_s = ST_SEND1;
                    else            state_next_s = ST_IDLE;
`else
                    state_next_s = ST_IDLE;
`endif
                end else begin
                    state_next_s = ST_SEND0;
                end
            end
`ifdef STORE_SPLIT_EN
            ST_SEND1: begin
                if (bus.wr_ready) state_next_s = ST_IDLE;
                else              state_next_s = ST_SEND1;
            end
`endif
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output/payload registers: load beat0 at accept, beat1 after beat0 is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_r    <= 1'b1;
            wr_valid_r <= 1'b0;
            wr_addr_r  <= '0;
            wr_data_r  <= '0;
            wr_strb_r  <= '0;
            wr_last_r  <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
`ifdef STORE_SPLIT_EN
            hi_data_r  <= '0;
            hi_strb_r  <= '0;
`endif
        end else begin
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            ready_r <= (state_next_s == ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (legal_s) begin
                            wr_valid_r <= 1'b1;
                            wr_addr_r  <= base_addr_s;
                            wr_data_r  <= lo_data_s;
                            wr_strb_r  <= mask2_s[STRB_WIDTH-1:0];
                            wr_last_r  <= ~cross_s;
`ifdef STORE_SPLIT_EN
                            hi_data_r  <= hi_data_s;
                            hi_strb_r  <= mask2_s[2*STRB_WIDTH-1:STRB_WIDTH];
`endif
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_SEND0: begin
                    if (bus.wr_ready) begin
`ifdef STORE_SPLIT_EN
                        if (!wr_last_r) begin
                            wr_addr_r <= wr_addr_r + ADDR_WIDTH'(STRB_WIDTH);
                            wr_data_r <= hi_data_r;
                            wr_strb_r <= hi_strb_r;
                            wr_last_r <= 1'b1;
                        end else begin
                            wr_valid_r <= 1'b0;
                            done_r     <= 1'b1;
                        end
`else
                        wr_valid_r <= 1'b0;
                        done_r     <= 1'b1;
`endif
                    end
                end
`ifdef STORE_SPLIT_EN
                ST_SEND1: begin
                    if (bus.wr_ready) begin
                        wr_valid_r <= 1'b0;
                        done_r     <= 1'b1;
                    end
                end
`endif
                default: begin
                    wr_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_r;
    assign bus.wr_valid  = wr_valid_r;
    assign bus.wr_addr   = wr_addr_r;
    assign bus.wr_data   = wr_data_r;
    assign bus.wr_strb   = wr_strb_r;
    assign bus.wr_last   = wr_last_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_memory_store_align.sv
// -----------------------------------------------------------------------------
// tb_memory_store_align
// Directed stimulus with a scoreboard: every issued store pushes its expected
// beats / done / err events into a queue; a negedge monitor pops and compares
// whenever the DUT shows a beat handshake, a done pulse or an err pulse.
// -----------------------------------------------------------------------------
module tb_memory_store_align;
    localparam int DW = 64;
    localparam int AW = 64;
    localparam int SW = 8;

    localparam int K_BEAT = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memory_store_align_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    memory_store_align #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   stall_cnt = 0;

    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    logic [SW-1:0] prev_strb;
    logic          prev_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_beat(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s, input logic l);
        exp_t e;
        e.kind = K_BEAT; e.addr = a; e.data = d; e.strb = s; e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic push_evt(input int k);
        exp_t e;
        e.kind = k; e.addr = '0; e.data = '0; e.strb = '0; e.last = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic pop_compare(input int k);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual_kind=%0d required=none", k);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 64'(k), 64'(e.kind));
            if (k == K_BEAT && e.kind == K_BEAT) begin
                check("beat_addr", bus.wr_addr, e.addr);
                check("beat_data", bus.wr_data, e.data);
                check("beat_strb", 64'(bus.wr_strb), 64'(e.strb));
                check("beat_last", 64'(bus.wr_last), 64'(e.last));
            end
        end
    endtask

    // Monitor: compare DUT events against the scoreboard and check stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(bus.wr_valid), 64'd1);
                check("stall_addr", bus.wr_addr, prev_addr);
                check("stall_data", bus.wr_data, prev_data);
                check("stall_strb", 64'(bus.wr_strb), 64'(prev_strb));
                check("stall_last", 64'(bus.wr_last), 64'(prev_last));
            end
            if (bus.done) pop_compare(K_DONE);
            if (bus.err) pop_compare(K_ERR);
            if (bus.wr_valid && bus.wr_ready) pop_compare(K_BEAT);
            if (bus.wr_valid && !bus.wr_ready) stall_cnt++;
            prev_stall = bus.wr_valid && !bus.wr_ready;
            prev_addr  = bus.wr_addr;
            prev_data  = bus.wr_data;
            prev_strb  = bus.wr_strb;
            prev_last  = bus.wr_last;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one request; sz = {double, word, half, byte}. Returns at the cycle after accept.
    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] sz,
                        output logic done_at_accept);
        int n;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            cycles(1);
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL send_ready_timeout actual=0 required=1");
        end
        done_at_accept = bus.done;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        {bus.is_double, bus.is_word, bus.is_half, bus.is_byte} = sz;
        cycles(1);
        bus.req_valid = 1'b0;
        {bus.is_double, bus.is_word, bus.is_half, bus.is_byte} = 4'b0000;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            cycles(1);
            n++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        cycles(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic d;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.is_byte   = 1'b0;
        bus.is_half   = 1'b0;
        bus.is_word   = 1'b0;
        bus.is_double = 1'b0;
        bus.wr_ready  = 1'b1;

        // Reset state
        rst_n = 1'b0;
        cycles(2);
        check("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
        check("rst_wr_last", 64'(bus.wr_last), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_wr_addr", bus.wr_addr, 64'd0);
        check("rst_wr_data", bus.wr_data, 64'd0);
        check("rst_wr_strb", 64'(bus.wr_strb), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        rst_n = 1'b1;
        cycles(1);

        // sb 0x8000_0003 data 0xAB
        push_beat(64'h0000_0000_8000_0000, 64'h0000_0000_AB00_0000, 8'h08, 1'b1);
        push_evt(K_DONE);
        send(64'h0000_0000_8000_0003, 64'h0000_0000_0000_00AB, 4'b0001, d);
        check("sb_valid_latency", 64'(bus.wr_valid), 64'd1);
        drain();

        // sd with wr_ready low for 3 cycles
        bus.wr_ready = 1'b0;
        push_beat(64'h0000_0000_0000_1000, 64'h1122_3344_5566_7788, 8'hFF, 1'b1);
        push_evt(K_DONE);
        stall_cnt = 0;
        send(64'h0000_0000_0000_1000, 64'h1122_3344_5566_7788, 4'b1000, d);
        cycles(3);
        bus.wr_ready = 1'b1;
        drain();
        check("sd_stall_cycles", 64'(stall_cnt), 64'd3);

        // sw 0x1006 crossing a bus word
`ifdef STORE_SPLIT_EN
        push_beat(64'h0000_0000_0000_1000, 64'hBEEF_0000_0000_0000, 8'hC0, 1'b0);
        push_beat(64'h0000_0000_0000_1008, 64'h0000_0000_0000_DEAD, 8'h03, 1'b1);
        push_evt(K_DONE);
        send(64'h0000_0000_0000_1006, 64'h0000_0000_DEAD_BEEF, 4'b0100, d);
        drain();
        // crossing store wrapping the address space
        push_beat(64'hFFFF_FFFF_FFFF_FFF8, 64'h5678_0000_0000_0000, 8'hC0, 1'b0);
        push_beat(64'h0000_0000_0000_0000, 64'h0000_0000_0000_1234, 8'h03, 1'b1);
        push_evt(K_DONE);
        send(64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_1234_5678, 4'b0100, d);
        drain();
`else
        push_evt(K_ERR);
        send(64'h0000_0000_0000_1006, 64'h0000_0000_DEAD_BEEF, 4'b0100, d);
        check("xw_err_pulse", 64'(bus.err), 64'd1);
        check("xw_req_ready", 64'(bus.req_ready), 64'd1);
        check("xw_no_valid", 64'(bus.wr_valid), 64'd0);
        cycles(1);
        check("xw_err_one_cycle", 64'(bus.err), 64'd0);
        check("xw_still_no_valid", 64'(bus.wr_valid), 64'd0);
        drain();
`endif

        // Illegal sizes: none set, two set
        push_evt(K_ERR);
        send(64'h0000_0000_0000_3000, 64'h0000_0000_0000_0055, 4'b0000, d);
        push_evt(K_ERR);
        send(64'h0000_0000_0000_3000, 64'h0000_0000_0000_0055, 4'b0011, d);
        check("bad_size_no_valid", 64'(bus.wr_valid), 64'd0);
        drain();

        // Back-to-back halves, upper request bits must be masked off
        bus.wr_ready = 1'b1;
        push_beat(64'h0000_0000_0000_2000, 64'h0000_0000_A1B2_0000, 8'h0C, 1'b1);
        push_evt(K_DONE);
        push_beat(64'h0000_0000_0000_2000, 64'h0000_C3D4_0000_0000, 8'h30, 1'b1);
        push_evt(K_DONE);
        send(64'h0000_0000_0000_2002, 64'hFFFF_FFFF_FFFF_A1B2, 4'b0010, d);
        send(64'h0000_0000_0000_2004, 64'h1111_2222_3333_C3D4, 4'b0010, d);
        check("b2b_accept_in_done_cycle", 64'(d), 64'd1);
        drain();

        // Reset while a beat is pending
        bus.wr_ready = 1'b0;
`ifdef STORE_SPLIT_EN
        push_beat(64'h0000_0000_0000_1000, 64'hBEEF_0000_0000_0000, 8'hC0, 1'b0);
        send(64'h0000_0000_0000_1006, 64'h0000_0000_DEAD_BEEF, 4'b0100, d);
        bus.wr_ready = 1'b1;
        cycles(1);
        bus.wr_ready = 1'b0;
`else
        send(64'h0000_0000_0000_2002, 64'h0000_0000_0000_A1B2, 4'b0010, d);
        cycles(1);
`endif
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        check("midrst_wr_valid", 64'(bus.wr_valid), 64'd0);
        check("midrst_req_ready", 64'(bus.req_ready), 64'd1);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_err", 64'(bus.err), 64'd0);
        bus.wr_ready = 1'b1;
        cycles(3);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
